instruction_fetch_unit: RTL

Front-end initiator for the instruction cache. It owns the program counter, presents it to the cache, and holds it stable until the cache returns the instruction. It buffers fetched instructions with their PCs in a 2-entry queue toward decode and throttles the cache when that queue is full. It also handles branch/jump redirects by reloading the PC and flushing everything queued.

---
 rtl/instruction_fetch_unit_if.sv | 30 +++
 rtl/instruction_fetch_unit.sv | 85 ++++++++
 2 files changed

// File: rtl/instruction_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_if
// Bundles the three buses around the fetch unit:
//   cache side  : pc, instruction, instruction_cache_ready, instruction_cache_stall
//   execute side: branch_taken, branch_target
//   decode side : if_instruction, if_pc, if_valid, id_ready
// master = the fetch unit, slave = the cache/execute/decode environment.
// ---------------------------------------------------------------------------
interface instruction_fetch_unit_if;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        instruction_cache_ready;
    logic        instruction_cache_stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        id_ready;

    modport master (
        output pc, instruction_cache_stall, if_instruction, if_pc, if_valid,
        input  instruction, instruction_cache_ready, branch_taken, branch_target, id_ready
    );

    modport slave (
        input  pc, instruction_cache_stall, if_instruction, if_pc, if_valid,
        output instruction, instruction_cache_ready, branch_taken, branch_target, id_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Owns the program counter, presents it to the instruction cache and holds it
// until the cache answers. Fetched {pc, instruction} pairs are buffered in a
// 2-entry queue toward decode; the cache is throttled while the queue is full.
// A taken branch reloads the PC and flushes the queue, and wins over every
// other event in that cycle.
// Ports:
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - instruction_fetch_unit_if.master (cache, execute and decode buses)
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    instruction_fetch_unit_if.master        bus
);
    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } entry_t;

    entry_t      fifo [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic [31:0] pc;

    logic stall;
    logic valid;
    logic accept;
    logic pop;

    // Stall comes from registered state only, so the cache never sees a
    // combinational path from any input through this block.
    assign stall  = (count == 2'd2) ? HIGH : LOW;
    assign valid  = (count != 2'd0) ? HIGH : LOW;
    assign accept = bus.instruction_cache_ready && !stall && !bus.branch_taken;
    assign pop    = valid && bus.id_ready && !bus.branch_taken;

    assign bus.pc                      = pc;
    assign bus.instruction_cache_stall = stall;
    assign bus.if_valid                = valid;
    assign bus.if_pc                   = fifo[rd_ptr].pc;
    assign bus.if_instruction          = fifo[rd_ptr].instruction;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            // NOTE: the queue storage is reset on purpose: IF_PC/IF_INSTRUCTION
            // are driven straight from it and must read zero out of reset.
            fifo[0] <= '0;
            fifo[1] <= '0;
        end else if (bus.branch_taken) begin
            // Redirect discards the cache response and any decode pop.
            pc     <= {bus.branch_target[31:2], 2'b00};
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (accept) begin
                fifo[wr_ptr] <= '{pc: pc, instruction: bus.instruction};
                wr_ptr       <= ~wr_ptr;
                pc           <= pc + 32'd4;  // wraps modulo 2^32
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Push and pop together leave the occupancy unchanged.
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule
